jk_bank_driver: RTL

Controller that drives J/K excitation inputs for a bank of WIDTH external JK flip-flops so that the bank reaches a requested target value. It reads back the bank's Q outputs, verifies them, and retries on mismatch. It is the driving end of the JK flip-flop interface and sits between sequencing logic (valid/ready target stream) and the flip-flop bank.

---
 rtl/jk_pkg.sv | 19 +
 rtl/jk_excite.sv | 30 +++
 rtl/jk_bank_driver.sv | 127 ++++++++++++
 3 files changed

// File: rtl/jk_pkg.sv
// Shared definitions for the JK flip-flop bank driver.
package jk_pkg;

    // Excitation codes, ordered {j, k}.
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    // Width of the retry counter; MAX_RETRY must fit in it.
    localparam int unsigned RETRY_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_e;

endpackage

// File: rtl/jk_excite.sv
// Per-bit JK excitation: picks the J/K pair that moves q to t on the next edge.
module jk_excite
    import jk_pkg::*;
#(
    parameter bit TOGGLE_PREF = 1'b0
) (
    input  logic q,
    input  logic t,
    output logic j,
    output logic k
);

    logic [1:0] code;

    // Hold when already correct, otherwise set/reset or toggle.
    always_comb begin
        code = JK_HOLD;
        if (q != t) begin
            if (TOGGLE_PREF) begin
                code = JK_TGL;
            end else if (t) begin
                code = JK_SET;
            end else begin
                code = JK_RST;
            end
        end
        {j, k} = code;
    end

endmodule

// File: rtl/jk_bank_driver.sv
// Drives a bank of JK flip-flops to a requested value, verifies via read-back, retries.
module jk_bank_driver
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter bit          TOGGLE_PREF = 1'b0,
    parameter int unsigned MAX_RETRY   = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_mask
);

    localparam logic [RETRY_W-1:0] MaxRetry = RETRY_W'(MAX_RETRY);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   target_q, target_d;
    logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
    logic [WIDTH-1:0]   j_q, j_d;
    logic [WIDTH-1:0]   k_q, k_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   err_mask_q, err_mask_d;

    logic [WIDTH-1:0]   exc_t;
    logic [WIDTH-1:0]   exc_j;
    logic [WIDTH-1:0]   exc_k;

    // In IDLE the incoming word is the target being latched this edge.
    assign exc_t = (state_q == IDLE) ? tgt_data : target_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_excite
        jk_excite #(
            .TOGGLE_PREF(TOGGLE_PREF)
        ) u_excite (
            .q(q_fb[i]),
            .t(exc_t[i]),
            .j(exc_j[i]),
            .k(exc_k[i])
        );
    end

    // Next-state logic; j/k are loaded only on entry to DRIVE.
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        retry_cnt_d = retry_cnt_q;
        j_d         = '0;
        k_d         = '0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        err_mask_d  = err_mask_q;
        unique case (state_q)
            IDLE: begin
                if (tgt_valid) begin
                    target_d    = tgt_data;
                    retry_cnt_d = '0;
                    j_d         = exc_j;
                    k_d         = exc_k;
                    state_d     = DRIVE;
                end
            end
            DRIVE: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (q_fb == target_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (retry_cnt_q < MaxRetry) begin
                    retry_cnt_d = retry_cnt_q + 1'b1;
                    j_d         = exc_j;
                    k_d         = exc_k;
                    state_d     = DRIVE;
                end else begin
                    err_d      = 1'b1;
                    err_mask_d = q_fb ^ target_q;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            target_q    <= '0;
            retry_cnt_q <= '0;
            j_q         <= '0;
            k_q         <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_mask_q  <= '0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            retry_cnt_q <= retry_cnt_d;
            j_q         <= j_d;
            k_q         <= k_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_mask_q  <= err_mask_d;
        end
    end

    assign tgt_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign j         = j_q;
    assign k         = k_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_mask  = err_mask_q;

endmodule
